// File: rtl/spi_rx_stream_pkg.sv
// Shared types and constants for the multi-lane SPI receive stream.
package spi_rx_pkg;

  localparam int SAMPLE_RISE = 0;
  localparam int SAMPLE_FALL = 1;

  typedef enum logic [1:0] {
    WAIT_CS,
    IDLE,
    RECV
  } rx_state_e;

  // A counter must be at least one bit wide, even for single-beat words.
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/spi_rx_stream_if.sv
// Word stream (valid/ready) from the SPI receiver toward the pixel pipeline.
interface spi_rx_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  sof_out;
  logic                  last_out;
  logic                  data_valid_out;
  logic                  data_ready_in;

  modport master (
    output data_out, sof_out, last_out, data_valid_out,
    input  data_ready_in
  );

  modport slave (
    input  data_out, sof_out, last_out, data_valid_out,
    output data_ready_in
  );
endinterface

// File: rtl/spi_rx_stream_fifo.sv
// Small synchronous FIFO with combinational head read; wrap bit on each pointer.
module spi_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/spi_rx_stream.sv
// Multi-lane SPI peripheral receiver: pin sync, word assembly, framed FIFO output.
// Optional SPI_RX_STREAM_WORD_COUNT_EN adds word_count_out (words pushed this frame).
module spi_rx_stream
  import spi_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LINES       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_EDGE = 0,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [LINES-1:0] chip_data_in,
  input  logic             chip_clk_in,
  input  logic             chip_sel_in,
  input  logic             final_pixel_in,
  spi_rx_stream_if.master  stream,
  output logic             overflow_out,
  output logic             frame_err_out,
  input  logic             clear_in,
  output logic             busy_out
`ifdef SPI_RX_STREAM_WORD_COUNT_EN
  ,
  output logic [15:0]      word_count_out
`endif
);
  localparam int BEATS   = DATA_WIDTH / LINES;
  localparam int CNT_W   = beat_cnt_width(BEATS);
  localparam int PIN_W   = LINES + 3;
  localparam int ENTRY_W = DATA_WIDTH + 2;

  typedef struct packed {
    logic                  sof;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } rx_entry_t;

  if (DATA_WIDTH % LINES != 0) begin : g_bad_width
    $error("spi_rx_stream: DATA_WIDTH must be a multiple of LINES");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_rx_stream: SYNC_STAGES must be at least 2");
  end

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_n;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_reg <= '0;
    else           rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  logic [PIN_W-1:0] sync_reg [SYNC_STAGES];
  logic             dclk_d_reg;
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
      dclk_d_reg <= 1'b0;
    end else begin
      sync_reg[0] <= {final_pixel_in, chip_sel_in, chip_clk_in, chip_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      dclk_d_reg <= sync_reg[SYNC_STAGES-1][LINES];
    end
  end

  logic [PIN_W-1:0] pins_s;
  logic [LINES-1:0] lanes_s;
  logic             dclk_s, cs_s, fp_s, edge_hit;
  assign pins_s  = sync_reg[SYNC_STAGES-1];
  assign lanes_s = pins_s[LINES-1:0];
  assign dclk_s  = pins_s[LINES];
  assign cs_s    = pins_s[LINES+1];
  assign fp_s    = pins_s[LINES+2];
  assign edge_hit = (SAMPLE_EDGE == SAMPLE_FALL) ? (dclk_d_reg & ~dclk_s)
                                                 : (dclk_s & ~dclk_d_reg);

  rx_state_e state_reg, state_next;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_reg <= WAIT_CS;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_CS: if (cs_s)  state_next = IDLE;
      IDLE:    if (!cs_s) state_next = RECV;
      RECV:    if (cs_s)  state_next = IDLE;
      default:            state_next = WAIT_CS;
    endcase
  end

  always_comb begin
    busy_out = (state_reg == RECV);
  end

  logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0]      beat_reg;
  logic                  sof_pending_reg, push_reg, frame_err_reg;
  rx_entry_t             entry_reg;

  genvar gi;
  for (gi = 0; gi < 1; gi++) begin : g_shift
    if (BEATS == 1) begin : g_single
      assign shreg_next = lanes_s;
    end else begin : g_multi
      assign shreg_next = {shreg_reg[DATA_WIDTH-LINES-1:0], lanes_s};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg       <= '0;
      beat_reg        <= '0;
      sof_pending_reg <= 1'b0;
      push_reg        <= 1'b0;
      frame_err_reg   <= 1'b0;
      entry_reg       <= '0;
    end else begin
      push_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      if (state_reg == IDLE && !cs_s) begin
        sof_pending_reg <= 1'b1;
        beat_reg        <= '0;
      end else if (state_reg == RECV) begin
        // CS rise takes priority over a coincident DCLK edge.
        if (cs_s) begin
          beat_reg      <= '0;
          shreg_reg     <= '0;
          frame_err_reg <= (beat_reg != '0);
        end else if (edge_hit) begin
          shreg_reg <= shreg_next;
          if (beat_reg == CNT_W'(BEATS - 1)) begin
            entry_reg       <= '{sof: sof_pending_reg, last: fp_s, data: shreg_next};
            push_reg        <= 1'b1;
            sof_pending_reg <= 1'b0;
            beat_reg        <= '0;
          end else begin
            beat_reg <= beat_reg + 1'b1;
          end
        end
      end
    end
  end

  rx_entry_t head;
  logic      fifo_full, fifo_empty, pop, drop, overflow_reg;

  assign pop  = ~fifo_empty & stream.data_ready_in;
  assign drop = push_reg & fifo_full & ~pop;

  spi_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n),
    .push      (push_reg),
    .push_data (entry_reg),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A new drop wins over a simultaneous clear.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)        overflow_reg <= 1'b0;
    else if (drop)     overflow_reg <= 1'b1;
    else if (clear_in) overflow_reg <= 1'b0;
  end

  assign stream.data_valid_out = ~fifo_empty;
  assign stream.data_out       = fifo_empty ? '0 : head.data;
  assign stream.sof_out        = ~fifo_empty & head.sof;
  assign stream.last_out       = ~fifo_empty & head.last;
  assign overflow_out          = overflow_reg;
  assign frame_err_out         = frame_err_reg;

`ifdef SPI_RX_STREAM_WORD_COUNT_EN
  logic [15:0] word_count_reg;
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      word_count_reg <= '0;
    end else if (state_reg == IDLE && !cs_s) begin
      word_count_reg <= '0;
    end else if (push_reg && word_count_reg != 16'hFFFF) begin
      word_count_reg <= word_count_reg + 16'd1;
    end
  end
  assign word_count_out = word_count_reg;
`endif

endmodule

// File: tb/tb_spi_rx_stream.sv
// Randomised bench for spi_rx_stream against a queue-based frame/word model.
module tb_spi_rx_stream;
  localparam int DW    = 8;
  localparam int LN    = 4;
  localparam int H     = 4;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  typedef logic [7:0] byte_q_t[$];
  typedef logic       bit_q_t[$];
  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default 4-lane, rising-edge build
  logic [LN-1:0] lanes = '0;
  logic dclk = 1'b0, cs = 1'b1, fp = 1'b0, clear = 1'b0;
  logic overflow, frame_err, busy;
  spi_rx_stream_if #(.DATA_WIDTH(DW)) s_a ();

  // Instance B: serial, falling-edge build
  logic lane_b = 1'b0, dclk_b = 1'b0, cs_b = 1'b1;
  logic ovf_b, ferr_b, busy_b;
  spi_rx_stream_if #(.DATA_WIDTH(8)) s_b ();

`ifdef SPI_RX_STREAM_WORD_COUNT_EN
  logic [15:0] wc_a, wc_b;
`endif

  spi_rx_stream #(
    .DATA_WIDTH(DW), .LINES(LN), .SYNC_STAGES(SYNC), .SAMPLE_EDGE(0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .chip_data_in(lanes), .chip_clk_in(dclk),
    .chip_sel_in(cs), .final_pixel_in(fp), .stream(s_a), .overflow_out(overflow),
    .frame_err_out(frame_err), .clear_in(clear), .busy_out(busy)
`ifdef SPI_RX_STREAM_WORD_COUNT_EN
    , .word_count_out(wc_a)
`endif
  );

  spi_rx_stream #(
    .DATA_WIDTH(8), .LINES(1), .SYNC_STAGES(SYNC), .SAMPLE_EDGE(1), .FIFO_DEPTH(DEPTH)
  ) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .chip_data_in(lane_b), .chip_clk_in(dclk_b),
    .chip_sel_in(cs_b), .final_pixel_in(1'b0), .stream(s_b), .overflow_out(ovf_b),
    .frame_err_out(ferr_b), .clear_in(1'b0), .busy_out(busy_b)
`ifdef SPI_RX_STREAM_WORD_COUNT_EN
    , .word_count_out(wc_b)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: words still owed to the consumer, and the sticky overflow flag.
  exp_t exp_q[$];
  logic exp_ovf = 1'b0;

  function automatic void model_push(input logic [7:0] d, input logic sof, input logic last);
    exp_t e;
    if (exp_q.size() >= DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      e.data = d; e.sof = sof; e.last = last;
      exp_q.push_back(e);
    end
  endfunction

  int rdy_mode = 1;  // 0 = hold off, 1 = always ready, 2 = random
  initial begin
    s_a.data_ready_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_a.data_ready_in = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  int pops = 0;
  always @(negedge clk) begin
    if (rst_n && s_a.data_valid_out && s_a.data_ready_in) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("spurious_word", {31'd0, s_a.data_valid_out}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("word %02h sof=%0d last=%0d (model %02h %0d %0d)",
                 s_a.data_out, s_a.sof_out, s_a.last_out, e.data, e.sof, e.last);
        check("data", {24'd0, s_a.data_out}, {24'd0, e.data});
        check("sof",  {31'd0, s_a.sof_out},  {31'd0, e.sof});
        check("last", {31'd0, s_a.last_out}, {31'd0, e.last});
      end
    end
  end

  int   ferr_pulses = 0;
  int   ferr_long   = 0;
  logic ferr_prev   = 1'b0;
  always @(negedge clk) begin
    if (frame_err && !ferr_prev) ferr_pulses++;
    if (frame_err && ferr_prev)  ferr_long++;
    ferr_prev <= frame_err;
  end

  task automatic send_word(input logic [7:0] w, input logic last, input int beats);
    for (int b = 0; b < beats; b++) begin
      @(negedge clk);
      lanes = w[7-4*b -: 4];
      fp    = (b == 1) ? last : 1'b0;
      repeat (H) @(negedge clk);
      dclk = 1'b1;
      repeat (H) @(negedge clk);
      dclk = 1'b0;
    end
  endtask

  task automatic send_frame(input byte_q_t w, input bit_q_t l);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    foreach (w[i]) begin
      send_word(w[i], l[i], 2);
      model_push(w[i], i == 0, l[i]);
    end
    repeat (H) @(negedge clk);
    cs = 1'b1;
    fp = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || s_a.data_valid_out) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t w;
    bit_q_t  l;
    int      pops_before, lat;
    s_b.data_ready_in = 1'b0;

    repeat (4) @(negedge clk);
    check("rst_valid",    {31'd0, s_a.data_valid_out}, 32'd0);
    check("rst_data",     {24'd0, s_a.data_out},       32'd0);
    check("rst_sof",      {31'd0, s_a.sof_out},        32'd0);
    check("rst_last",     {31'd0, s_a.last_out},       32'd0);
    check("rst_overflow", {31'd0, overflow},           32'd0);
    check("rst_frame_err",{31'd0, frame_err},          32'd0);
    check("rst_busy",     {31'd0, busy},               32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Basic three-word frame
    w = '{8'hA5, 8'h3C, 8'hFF}; l = '{1'b0, 1'b0, 1'b0};
    send_frame(w, l);
    wait_drain();
    check("frame1_no_ferr", ferr_pulses, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // final_pixel on the middle word
    w = '{8'h10, 8'h81, 8'h22}; l = '{1'b0, 1'b1, 1'b0};
    send_frame(w, l);
    wait_drain();

    // Partial word then CS rise
    cs = 1'b0;
    repeat (6) @(negedge clk);
    send_word(8'h77, 1'b0, 1);
    check("partial_busy", {31'd0, busy}, 32'd1);
    repeat (H) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    check("partial_ferr_pulses", ferr_pulses, 32'd1);
    check("partial_ferr_width",  ferr_long,   32'd0);
    w = '{8'h44, 8'h55}; l = '{1'b0, 1'b0};
    send_frame(w, l);
    wait_drain();

    // Random frames with a random consumer
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      int nw;
      nw = $urandom_range(1, 5);
      w.delete(); l.delete();
      for (int i = 0; i < nw; i++) begin
        w.push_back(8'($urandom_range(0, 255)));
        l.push_back((i == nw - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      send_frame(w, l);
      wait_drain();
    end
    check("rand_overflow", {31'd0, overflow}, {31'd0, exp_ovf});

    // Overflow: ten words into an eight-deep FIFO with the consumer stalled
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    w.delete(); l.delete();
    for (int i = 0; i < 10; i++) begin
      w.push_back(8'($urandom_range(0, 255)));
      l.push_back(1'b0);
    end
    send_frame(w, l);
    check("ovf_set",   {31'd0, overflow}, {31'd0, exp_ovf});
    check("ovf_valid", {31'd0, s_a.data_valid_out}, 32'd1);
    pops_before = pops;
    rdy_mode = 1;
    wait_drain();
    check("ovf_drained", pops - pops_before, 32'd8);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0; exp_ovf = 1'b0;
    check("ovf_clear", {31'd0, overflow}, {31'd0, exp_ovf});

    // Reset in the middle of a frame with CS held low
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    send_word(8'h99, 1'b0, 2);
    model_push(8'h99, 1'b1, 1'b0);
    send_word(8'h66, 1'b0, 1);
    check("pre_reset_valid", {31'd0, s_a.data_valid_out}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_reset_valid", {31'd0, s_a.data_valid_out}, 32'd0);
    check("mid_reset_data",  {24'd0, s_a.data_out},       32'd0);
    check("mid_reset_busy",  {31'd0, busy},               32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    pops_before = pops;
    send_word(8'hC3, 1'b0, 2);
    send_word(8'h3C, 1'b0, 2);
    repeat (6) @(negedge clk);
    check("post_reset_ignored", pops - pops_before, 32'd0);
    check("post_reset_valid", {31'd0, s_a.data_valid_out}, 32'd0);
    check("post_reset_busy",  {31'd0, busy}, 32'd0);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    w = '{8'h12, 8'h34}; l = '{1'b0, 1'b1};
    send_frame(w, l);
    wait_drain();

    // Serial falling-edge instance: 0x5A, latency from the final DCLK fall
    cs_b = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      logic [7:0] wb;
      wb = 8'h5A;
      @(negedge clk);
      lane_b = wb[7-b];
      repeat (H) @(negedge clk);
      dclk_b = 1'b1;
      repeat (H) @(negedge clk);
      if (b < 7) dclk_b = 1'b0;
    end
    check("b_valid_before", {31'd0, s_b.data_valid_out}, 32'd0);
    dclk_b = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_b.data_valid_out && lat < 20);
    $display("serial word %02h sof=%0d latency=%0d", s_b.data_out, s_b.sof_out, lat);
    check("b_latency", lat, SYNC + 2);
    check("b_data", {24'd0, s_b.data_out}, 32'h5A);
    check("b_sof",  {31'd0, s_b.sof_out},  32'd1);
    check("b_last", {31'd0, s_b.last_out}, 32'd0);
    s_b.data_ready_in = 1'b1;
    @(negedge clk);
    s_b.data_ready_in = 1'b0;
    check("b_popped", {31'd0, s_b.data_valid_out}, 32'd0);
    cs_b = 1'b1;
    repeat (8) @(negedge clk);

    check("final_ferr_pulses", ferr_pulses, 32'd1);
    check("final_ferr_width",  ferr_long,   32'd0);
    check("final_model_empty", exp_q.size(), 32'd0);
    check("final_overflow", {31'd0, overflow}, {31'd0, exp_ovf});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
